// File: rtl/ifid_fetch_stage_if.sv
// Instruction-memory fetch bus: request/acknowledge handshake with a
// variable-latency memory.
interface ifid_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifid_fetch_stage.sv
// Fetch front end: PC, imem handshake and IF/ID register. A small FSM covers
// stall buffering (HOLD) and discarding a wrong-path outstanding fetch (DROP).
module ifid_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pc_write,
  input  logic                       ifid_write,
  input  logic                       ifid_flush,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  ifid_fetch_stage_if.master         imem,
  output logic [31:0]                if2id_instr,
  output logic [31:0]                if2id_pc_plus4,
  output logic                       if2id_valid,
  output logic [4:0]                 if2id_rs,
  output logic [4:0]                 if2id_rt
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] instr_q, pc4_q;
  logic        valid_q;

  logic        req;
  logic        take;
  logic        deliver;
  logic [31:0] dlv_instr, dlv_pc4;
  logic [31:0] pc_plus4;

  // A redirect while the PC is frozen is dropped entirely.
  assign take     = redirect & pc_write;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    pend_d      = pend_q;
    deliver     = 1'b0;
    dlv_instr   = buf_instr_q;
    dlv_pc4     = buf_pc4_q;
    req         = 1'b0;
    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (imem.imem_ack) begin
          if (take) begin
            pc_d = redirect_pc;
          end else if (pc_write && ifid_write) begin
            deliver   = 1'b1;
            dlv_instr = imem.imem_rdata;
            dlv_pc4   = pc_plus4;
            pc_d      = pc_plus4;
          end else begin
            // Word arrived but cannot be consumed: park it, PC stays put.
            buf_instr_d = imem.imem_rdata;
            buf_pc4_d   = pc_plus4;
            state_d     = S_HOLD;
          end
        end else if (take) begin
          pend_d  = redirect_pc;
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (take) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (pc_write && ifid_write) begin
          deliver = 1'b1;
          pc_d    = pc_plus4;
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        // Address must stay stable until the stale request is acked.
        req = 1'b1;
        if (take) pend_d = redirect_pc;
        if (imem.imem_ack) begin
          pc_d    = take ? redirect_pc : pend_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      buf_instr_q <= 32'h0;
      buf_pc4_q   <= 32'h0;
      pend_q      <= 32'h0;
      instr_q     <= 32'h0;
      pc4_q       <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      pend_q      <= pend_d;
      if (ifid_flush || (ifid_write && !deliver)) begin
        instr_q <= 32'h0;
        pc4_q   <= 32'h0;
        valid_q <= 1'b0;
      end else if (ifid_write) begin
        instr_q <= dlv_instr;
        pc4_q   <= dlv_pc4;
        valid_q <= 1'b1;
      end
    end
  end

  assign imem.imem_req  = req & ~reset;
  assign imem.imem_addr = pc_q;

  assign if2id_instr    = instr_q;
  assign if2id_pc_plus4 = pc4_q;
  assign if2id_valid    = valid_q;
  assign if2id_rs       = instr_q[25:21];
  assign if2id_rt       = instr_q[20:16];

endmodule
